mx_int_block_gen: RTL and testbench

//  Synthesizable, parametrised MXINT block stimulus source: emits shared-scale blocks of signed

---
 rtl/mx_gen_pkg.sv | 48 ++++
 rtl/mx_lfsr32.sv | 50 +++++
 rtl/mx_int_block_gen.sv | 245 ++++++++++++++++++++++++
 tb/tb_mx_int_block_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mx_gen_pkg.sv
// Shared types, constants and sizing helpers for the MXINT block stimulus generator.
package mx_gen_pkg;

    typedef enum logic [3:0] {
        CASE_NORMAL            = 4'd0,
        CASE_POS               = 4'd1,
        CASE_NEG               = 4'd2,
        CASE_SMALL             = 4'd3,
        CASE_BIG               = 4'd4,
        CASE_ALL_ZERO          = 4'd5,
        CASE_ONE_ZERO          = 4'd6,
        CASE_ALL_NAN           = 4'd7,
        CASE_ONE_NAN           = 4'd8,
        CASE_POS_CARRY         = 4'd9,
        CASE_NEG_CARRY         = 4'd10,
        CASE_SCALE_NAN         = 4'd11,
        CASE_SCALE_NAN_ONE_NAN = 4'd12
    } mx_case_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_NEXT,
        ST_FIN
    } gen_state_e;

    localparam int          NUM_CASES = 13;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic int max_pos(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int min_code(input int w);
        return 1 << (w - 1);
    endfunction

    // All-ones pattern of width w (w in 1..32), right-aligned.
    function automatic logic [31:0] scale_nan(input int w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

    function automatic int beat_cnt_w(input int block_size, input int lanes);
        return (block_size / lanes > 1) ? $clog2(block_size / lanes) : 1;
    endfunction

endpackage

// File: rtl/mx_lfsr32.sv
// 32-bit Galois LFSR (x^32+x^22+x^2+x+1) exposing STEPS consecutive future states per cycle.
module mx_lfsr32
    import mx_gen_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'hACE1_2468,
    parameter int          STEPS = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   seed_ld_i,
    input  logic                   en_i,
    input  logic                   long_i,
    output logic [STEPS-1:0][31:0] draw_o
);

    logic [31:0] state_q, state_d;
    logic [31:0] walk;

    function automatic logic [31:0] step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    always_comb begin
        walk   = state_q;
        draw_o = '0;
        for (int k = 0; k < STEPS; k++) begin
            walk      = step(walk);
            draw_o[k] = walk;
        end
    end

    // long_i consumes all STEPS draws, otherwise one fewer.
    always_comb begin
        state_d = state_q;
        if (seed_ld_i) begin
            state_d = SEED;
        end else if (en_i) begin
            state_d = long_i ? draw_o[STEPS-1] : draw_o[STEPS-2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/mx_int_block_gen.sv
// MXINT block stimulus source: streams REPS shared-scale blocks per corner-case class as
// LANES-wide beats over valid/ready, with a registered output stage.
module mx_int_block_gen
    import mx_gen_pkg::*;
#(
    parameter int          ELEM_W     = 8,
    parameter int          SCALE_W    = 8,
    parameter int          BLOCK_SIZE = 32,
    parameter int          LANES      = 8,
    parameter int          REPS       = 5,
    parameter logic [31:0] SEED       = 32'hACE1_2468
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    sweep,
    input  logic [3:0]              mode_sel,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [SCALE_W-1:0]      o_scale,
    output logic [LANES*ELEM_W-1:0] o_elems,
    output logic                    o_first,
    output logic                    o_last,
    output logic [3:0]              o_case_id,
    output logic                    busy,
    output logic                    done
);

    localparam int BEATS  = BLOCK_SIZE / LANES;
    localparam int BEAT_W = beat_cnt_w(BLOCK_SIZE, LANES);
    localparam int IDX_W  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int REP_W  = (REPS > 1) ? $clog2(REPS) : 1;

    localparam logic [ELEM_W-1:0]  MAXV      = ELEM_W'(max_pos(ELEM_W));
    localparam logic [ELEM_W-1:0]  MINV      = ELEM_W'(min_code(ELEM_W));
    localparam logic [SCALE_W-1:0] SNAN      = SCALE_W'(scale_nan(SCALE_W));
    localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [REP_W-1:0]   REP_LAST  = REP_W'(REPS - 1);
    localparam logic [3:0]         NUM_C4    = 4'(NUM_CASES);
    localparam logic [3:0]         LAST_C4   = 4'(NUM_CASES - 1);

    gen_state_e                 state_q, state_d;
    logic [REP_W-1:0]           rep_q, rep_d;
    logic [3:0]                 case_q, case_d;
    logic                       sweep_q, sweep_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic [IDX_W-1:0]           sidx_q, sidx_d;
    logic                       valid_q, valid_d;
    logic [SCALE_W-1:0]         scale_q, scale_d;
    logic [LANES*ELEM_W-1:0]    elems_q, elems_d;
    logic                       first_q, first_d;
    logic                       last_q, last_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic [LANES:0][31:0]       draw;
    logic                       lfsr_en, lfsr_seed, in_load, xfer;
    logic [BEAT_W-1:0]          beat_nxt, beat_use;
    logic [IDX_W-1:0]           sidx_new, sidx_use;
    logic [SCALE_W-1:0]         scale_new;
    logic [LANES*ELEM_W-1:0]    elems_new;
    mx_case_e                   cls;

    mx_lfsr32 #(
        .SEED  (SEED),
        .STEPS (LANES + 1)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_ld_i (lfsr_seed),
        .en_i      (lfsr_en),
        .long_i    (in_load),
        .draw_o    (draw)
    );

    function automatic logic [ELEM_W-1:0] gen_elem(input mx_case_e c, input logic [31:0] r,
                                                   input logic at_sidx);
        logic [ELEM_W-1:0] code, mag, res;
        code = r[ELEM_W-1:0];
        mag  = MAXV - ELEM_W'(r[1:0]);
        res  = code;
        case (c)
            CASE_POS:       res = {1'b0, code[ELEM_W-2:0]};
            CASE_NEG:       res = ~(code % MAXV);   // -(m+1) == ~m, never reaches the min code
            CASE_SMALL:     res = (code % ELEM_W'(7)) - ELEM_W'(3);
            CASE_BIG:       res = r[ELEM_W] ? -mag : mag;
            CASE_ALL_ZERO:  res = '0;
            CASE_ONE_ZERO:  res = at_sidx ? '0 : code;
            CASE_ALL_NAN:   res = MINV;
            // Random min codes are nudged to -MAX so the special index holds the only one.
            CASE_ONE_NAN, CASE_SCALE_NAN_ONE_NAN:
                res = at_sidx ? MINV : ((code == MINV) ? (MINV + ELEM_W'(1)) : code);
            CASE_POS_CARRY: res = MAXV;
            CASE_NEG_CARRY: res = -MAXV;
            default:        res = code;
        endcase
        return res;
    endfunction

    function automatic logic [SCALE_W-1:0] gen_scale(input mx_case_e c, input logic [31:0] r);
        logic [SCALE_W-1:0] s;
        s = r[31 -: SCALE_W];
        if (c == CASE_SCALE_NAN || c == CASE_SCALE_NAN_ONE_NAN) begin
            s = SNAN;
        end else if (s == SNAN) begin
            s = s ^ SCALE_W'(1);
        end
        return s;
    endfunction

    // In LOAD draw[0] feeds scale/sidx and lanes take draw[1..LANES]; mid-block lanes take draw[0..].
    always_comb begin
        cls       = mx_case_e'(case_q);
        in_load   = (state_q == ST_LOAD);
        xfer      = valid_q && o_ready;
        beat_nxt  = beat_q + 1'b1;
        sidx_new  = IDX_W'(draw[0] % 32'(BLOCK_SIZE));
        scale_new = gen_scale(cls, draw[0]);
        sidx_use  = in_load ? sidx_new : sidx_q;
        beat_use  = in_load ? '0 : beat_nxt;
        elems_new = '0;
        for (int l = 0; l < LANES; l++) begin
            elems_new[l*ELEM_W +: ELEM_W] = gen_elem(cls, in_load ? draw[l+1] : draw[l],
                (int'(beat_use) * LANES + l) == int'(sidx_use));
        end
    end

    always_comb begin
        state_d   = state_q;
        rep_d     = rep_q;
        case_d    = case_q;
        sweep_d   = sweep_q;
        beat_d    = beat_q;
        sidx_d    = sidx_q;
        valid_d   = valid_q;
        scale_d   = scale_q;
        elems_d   = elems_q;
        first_d   = first_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        lfsr_en   = 1'b0;
        lfsr_seed = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    busy_d    = 1'b1;
                    lfsr_seed = 1'b1;
                    rep_d     = '0;
                    beat_d    = '0;
                    sweep_d   = sweep;
                    case_d    = (sweep || mode_sel >= NUM_C4) ? 4'd0 : mode_sel;
                end
            end
            ST_LOAD: begin
                state_d = ST_STREAM;
                lfsr_en = 1'b1;
                valid_d = 1'b1;
                scale_d = scale_new;
                sidx_d  = sidx_new;
                elems_d = elems_new;
                beat_d  = '0;
                first_d = 1'b1;
                last_d  = (BEATS == 1);
            end
            ST_STREAM: begin
                if (xfer) begin
                    if (last_q) begin
                        state_d = ST_NEXT;
                        valid_d = 1'b0;
                        first_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        lfsr_en = 1'b1;
                        beat_d  = beat_nxt;
                        elems_d = elems_new;
                        first_d = 1'b0;
                        last_d  = (beat_nxt == BEAT_LAST);
                    end
                end
            end
            ST_NEXT: begin
                if (rep_q == REP_LAST) begin
                    rep_d = '0;
                    if (sweep_q && case_q != LAST_C4) begin
                        case_d  = case_q + 4'd1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    rep_d   = rep_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rep_q   <= '0;
            case_q  <= '0;
            sweep_q <= 1'b0;
            beat_q  <= '0;
            sidx_q  <= '0;
            valid_q <= 1'b0;
            scale_q <= '0;
            elems_q <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            case_q  <= case_d;
            sweep_q <= sweep_d;
            beat_q  <= beat_d;
            sidx_q  <= sidx_d;
            valid_q <= valid_d;
            scale_q <= scale_d;
            elems_q <= elems_d;
            first_q <= first_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_scale   = scale_q;
    assign o_elems   = elems_q;
    assign o_first   = first_q;
    assign o_last    = last_q;
    assign o_case_id = case_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mx_int_block_gen.sv
// Randomised bench for mx_int_block_gen against a queue-based block model built from the class rules.
module tb_mx_int_block_gen;

    localparam int          ELEM_W     = 8;
    localparam int          SCALE_W    = 8;
    localparam int          BLOCK_SIZE = 32;
    localparam int          LANES      = 8;
    localparam int          REPS       = 5;
    localparam int          BEATS      = BLOCK_SIZE / LANES;
    localparam logic [31:0] SEED       = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sweep = 1'b0;
    logic [3:0]  mode_sel = 4'd0;
    logic        o_ready = 1'b0;
    logic        o_valid, o_first, o_last, busy, done;
    logic [7:0]  o_scale;
    logic [63:0] o_elems;
    logic [3:0]  o_case_id;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  scale;
        logic [63:0] elems;
        logic        first;
        logic        last;
        logic [3:0]  cid;
        int          sidx;
    } beat_t;

    beat_t exp_q[$];

    mx_int_block_gen #(
        .ELEM_W(ELEM_W), .SCALE_W(SCALE_W), .BLOCK_SIZE(BLOCK_SIZE),
        .LANES(LANES), .REPS(REPS), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sweep(sweep), .mode_sel(mode_sel),
        .o_valid(o_valid), .o_ready(o_ready), .o_scale(o_scale), .o_elems(o_elems),
        .o_first(o_first), .o_last(o_last), .o_case_id(o_case_id), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic int elem_val(input int cls, input logic [31:0] r, input bit at_sidx);
        int code;
        int v;
        code = int'(r[7:0]);
        case (cls)
            1:       v = code % 128;
            2:       v = -((code % 127) + 1);
            3:       v = (code % 7) - 3;
            4:       v = r[8] ? -(127 - code % 4) : (127 - code % 4);
            5:       v = 0;
            6:       v = at_sidx ? 0 : code;
            7:       v = 128;
            8, 12:   v = at_sidx ? 128 : ((code == 128) ? 129 : code);
            9:       v = 127;
            10:      v = -127;
            default: v = code;
        endcase
        return v & 255;
    endfunction

    task automatic build_model(input bit sw, input logic [3:0] md);
        logic [31:0] s;
        logic [7:0]  sc;
        logic [63:0] e;
        int          c0, c1, sidx;
        beat_t       b;
        exp_q.delete();
        s  = SEED;
        c0 = sw ? 0 : ((md < 13) ? int'(md) : 0);
        c1 = sw ? 12 : c0;
        for (int c = c0; c <= c1; c++) begin
            for (int rep = 0; rep < REPS; rep++) begin
                s  = lfsr_next(s);
                sc = s[31:24];
                if (c == 11 || c == 12) sc = 8'hFF;
                else if (sc == 8'hFF)   sc = 8'hFE;
                sidx = int'(s % 32'(BLOCK_SIZE));
                for (int bt = 0; bt < BEATS; bt++) begin
                    e = '0;
                    for (int l = 0; l < LANES; l++) begin
                        s = lfsr_next(s);
                        e[l*8 +: 8] = 8'(elem_val(c, s, (bt * LANES + l) == sidx));
                    end
                    b.scale = sc;
                    b.elems = e;
                    b.first = (bt == 0);
                    b.last  = (bt == BEATS - 1);
                    b.cid   = 4'(c);
                    b.sidx  = sidx;
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    task automatic run(input bit sw, input logic [3:0] md, input int rdy_pct,
                       input int abort_at, input string nm);
        int          nexp, got, dones, busy_low, bsum, nan_cnt, nan_pos, c, cyc;
        bit          prev_stall, timed_out, aborted;
        logic [63:0] p_elems;
        logic [14:0] p_ctl;
        logic [7:0]  byt;
        beat_t       e;
        build_model(sw, md);
        nexp = exp_q.size();
        got = 0; dones = 0; busy_low = 0; bsum = 0; nan_cnt = 0; nan_pos = -1;
        prev_stall = 1'b0; timed_out = 1'b1; aborted = 1'b0;
        p_elems = '0; p_ctl = '0;
        @(negedge clk);
        sweep = sw; mode_sel = md; start = 1'b1; o_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "/load_valid"}, 64'(o_valid), 64'd0);
        chk({nm, "/load_busy"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk({nm, "/valid_rise"}, 64'(o_valid), 64'd1);
        for (cyc = 0; cyc < 6000; cyc++) begin
            if (prev_stall) begin
                chk({nm, "/stall_elems"}, o_elems, p_elems);
                chk({nm, "/stall_ctl"}, 64'({o_valid, o_first, o_last, o_case_id, o_scale}),
                    64'(p_ctl));
            end
            o_ready  = ($urandom_range(99) < rdy_pct);
            start    = (got < nexp - 1) && ($urandom_range(3) == 0);
            mode_sel = 4'($urandom_range(15));
            if (o_valid && o_ready) begin
                if (got < nexp) begin
                    e = exp_q[got];
                    chk({nm, "/elems"}, o_elems, e.elems);
                    chk({nm, "/scale"}, 64'(o_scale), 64'(e.scale));
                    chk({nm, "/ctl"}, 64'({o_first, o_last, o_case_id}),
                        64'({e.first, e.last, e.cid}));
                    for (int l = 0; l < LANES; l++) begin
                        byt  = o_elems[l*8 +: 8];
                        bsum += int'($signed(byt));
                        if (byt == 8'h80) begin
                            nan_cnt++;
                            nan_pos = ((got % BEATS) * LANES) + l;
                        end
                    end
                    if (e.last) begin
                        c = int'(e.cid);
                        if (c == 9) chk({nm, "/carry_sum"}, 64'(bsum), 64'd4064);
                        if (c == 8 || c == 12) begin
                            chk({nm, "/nan_count"}, 64'(nan_cnt), 64'd1);
                            chk({nm, "/nan_pos"}, 64'(nan_pos), 64'(e.sidx));
                        end
                        if ((c >= 1 && c <= 5) || c == 9 || c == 10)
                            chk({nm, "/no_min_code"}, 64'(nan_cnt), 64'd0);
                        if (c == 11 || c == 12) chk({nm, "/scale_nan"}, 64'(o_scale), 64'hFF);
                        else chk({nm, "/scale_not_nan"}, 64'(o_scale != 8'hFF), 64'd1);
                        bsum = 0; nan_cnt = 0; nan_pos = -1;
                    end
                end else begin
                    chk({nm, "/extra_beat"}, 64'(got), 64'(nexp));
                end
                got++;
                if (got - 1 == abort_at) begin
                    rst_n = 1'b0;
                    start = 1'b0;
                    #1;
                    chk({nm, "/abort_ctl"}, 64'({o_valid, o_first, o_last, busy, done,
                        o_case_id, o_scale}), 64'd0);
                    chk({nm, "/abort_elems"}, o_elems, 64'd0);
                    aborted   = 1'b1;
                    timed_out = 1'b0;
                    break;
                end
            end
            if (!busy && !done) busy_low++;
            if (done) begin
                dones++;
                chk({nm, "/done_busy"}, 64'(busy), 64'd0);
                timed_out = 1'b0;
                break;
            end
            prev_stall = o_valid && !o_ready;
            p_elems    = o_elems;
            p_ctl      = {o_valid, o_first, o_last, o_case_id, o_scale};
            @(negedge clk);
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            rst_n = 1'b1;
            dones = 0;
            repeat (6) begin
                @(negedge clk);
                if (done) dones++;
            end
            chk({nm, "/abort_no_done"}, 64'(dones), 64'd0);
            chk({nm, "/abort_idle"}, 64'({o_valid, busy}), 64'd0);
        end else begin
            chk({nm, "/timeout"}, 64'(timed_out), 64'd0);
            chk({nm, "/beats"}, 64'(got), 64'(nexp));
            chk({nm, "/done_count"}, 64'(dones), 64'd1);
            chk({nm, "/busy_low"}, 64'(busy_low), 64'd0);
            @(negedge clk);
            chk({nm, "/done_pulse"}, 64'({done, busy, o_valid}), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 64'({o_valid, o_first, o_last, busy, done, o_case_id, o_scale}), 64'd0);
        chk("rst_elems", o_elems, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'({busy, o_valid}), 64'd0);
        run(1'b1, 4'd0,  100, -1, "sweep");
        run(1'b0, 4'd9,  100, -1, "pos_carry");
        run(1'b0, 4'd8,  50,  -1, "one_nan");
        run(1'b0, 4'd11, 100, -1, "scale_nan");
        run(1'b0, 4'd15, 70,  -1, "mode15");
        run(1'b0, 4'd0,  50,  -1, "stall");
        run(1'b0, 4'd0,  100, 3 * BEATS + 2, "abort");
        run(1'b0, 4'd0,  100, -1, "restart");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
